// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, flag bit positions, result-stage entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: OP_* 5-bit opcodes, FLAG_Z/FLAG_N indices, result_entry_t, is_alu_wb_op().
package cpu_pkg;

  // Datapath widths the entry struct is built for; the result stage's
  // DATA_W/REG_AW parameters must match these.
  localparam int CPU_DATA_W = 32;
  localparam int CPU_REG_AW = 5;

  // Architectural flag register bit positions.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;

  // Opcode encodings. 5'b10010 and 5'b11010..5'b11111 are unassigned.
  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_SUBI  = 5'b00011;
  localparam logic [4:0] OP_MUL   = 5'b00100;
  localparam logic [4:0] OP_DIV   = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b00110;
  localparam logic [4:0] OP_ANDI  = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_ORI   = 5'b01001;
  localparam logic [4:0] OP_NOT   = 5'b01010;
  localparam logic [4:0] OP_XOR   = 5'b01011;
  localparam logic [4:0] OP_XORI  = 5'b01100;
  localparam logic [4:0] OP_MOVEL = 5'b01101;
  localparam logic [4:0] OP_MOVEH = 5'b01110;
  localparam logic [4:0] OP_LD    = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_CMP   = 5'b10001;
  localparam logic [4:0] OP_BEQ   = 5'b10011;
  localparam logic [4:0] OP_BNE   = 5'b10100;
  localparam logic [4:0] OP_BLT   = 5'b10101;
  localparam logic [4:0] OP_BGT   = 5'b10110;
  localparam logic [4:0] OP_CALL  = 5'b10111;
  localparam logic [4:0] OP_RET   = 5'b11000;
  localparam logic [4:0] OP_RETI  = 5'b11001;

  // One held result: writeback, memory and branch effects of a single op.
  typedef struct packed {
    logic                  wb_en;
    logic [CPU_REG_AW-1:0] wb_rd;
    logic [CPU_DATA_W-1:0] wb_data;
    logic                  mem_req;
    logic                  mem_we;
    logic [CPU_DATA_W-1:0] mem_addr;
    logic [CPU_DATA_W-1:0] mem_wdata;
    logic                  br_taken;
    logic [CPU_DATA_W-1:0] br_target;
  } result_entry_t;

  // Ops whose ALU result is written straight back to rd.
  function automatic logic is_alu_wb_op(input logic [4:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV,
      OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation against the architectural flag register.
// Latency: combinational.
// Backpressure: none (pure function of opcode and flags).
// Ports: opcode (5b decoded op), flags (2b, [FLAG_Z]/[FLAG_N]), taken (1 = branch taken).
module branch_cond
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [1:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = flags[FLAG_Z];
      OP_BNE:  taken = !flags[FLAG_Z];
      OP_BLT:  taken = flags[FLAG_N];
      OP_BGT:  taken = !flags[FLAG_N] && !flags[FLAG_Z];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Turns ALU result + flags + opcode into writeback, memory and branch requests; holds flags_q.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: single-entry valid/ready register, in_ready = !out_valid | out_ready.
// Ports: clk/rst (sync, active-high), flush, in_* execute-stage op with in_valid/in_ready,
//   out_* held entry with out_valid/out_ready, flags_q architectural flags ([0]=Z, [1]=N).
// Option: define FLAGS_ON_ARITH_EN to also load flags_q on accepted arithmetic/logic ops.
module alu_result_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [1:0]        in_flags,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rd_old,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [DATA_W-1:0] in_br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic [REG_AW-1:0] out_wb_rd,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              out_mem_req,
  output logic              out_mem_we,
  output logic [DATA_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_wdata,
  output logic              out_br_taken,
  output logic [DATA_W-1:0] out_br_target,
  output logic [1:0]        flags_q
);

  localparam int HALF_W = DATA_W / 2;

  result_entry_t entry_q;
  result_entry_t entry_d;
  logic          accept;
  logic          br_taken;
  logic          flags_upd;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Branches see flags_q as it stands before this accept's own update.
  branch_cond u_branch_cond (
    .opcode (in_opcode),
    .flags  (flags_q),
    .taken  (br_taken)
  );

  // Fields not relevant to an op stay 0 so the held entry is fully deterministic.
  always_comb begin
    entry_d = '0;
    if (is_alu_wb_op(in_opcode)) begin
      entry_d.wb_en   = 1'b1;
      entry_d.wb_rd   = in_rd;
      entry_d.wb_data = in_alu_out;
    end
    case (in_opcode)
      OP_MOVEL: begin
        entry_d.wb_en   = 1'b1;
        entry_d.wb_rd   = in_rd;
        entry_d.wb_data = {in_rd_old[DATA_W-1:HALF_W], in_alu_out[HALF_W-1:0]};
      end
      OP_MOVEH: begin
        entry_d.wb_en   = 1'b1;
        entry_d.wb_rd   = in_rd;
        entry_d.wb_data = {in_alu_out[DATA_W-1:HALF_W], in_rd_old[HALF_W-1:0]};
      end
      // LD's writeback comes from the memory return path, not from here.
      OP_LD: begin
        entry_d.mem_req  = 1'b1;
        entry_d.mem_addr = in_alu_out;
      end
      OP_ST: begin
        entry_d.mem_req   = 1'b1;
        entry_d.mem_we    = 1'b1;
        entry_d.mem_addr  = in_alu_out;
        entry_d.mem_wdata = in_store_data;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGT: begin
        entry_d.br_taken  = br_taken;
        entry_d.br_target = in_br_target;
      end
      // CALL/RET/RETI and unassigned codes carry no request; control unit owns them.
      default: ;
    endcase
  end

  always_comb begin
`ifdef FLAGS_ON_ARITH_EN
    flags_upd = (in_opcode == OP_CMP) || is_alu_wb_op(in_opcode);
`else
    flags_upd = (in_opcode == OP_CMP);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      entry_q   <= '0;
      flags_q   <= 2'b00;
    end else if (flush) begin
      // Flush drops both the held entry and whatever is being offered.
      out_valid <= 1'b0;
      entry_q   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      entry_q   <= entry_d;
      if (flags_upd) begin
        flags_q <= in_flags;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      entry_q   <= '0;
    end
  end

  assign out_wb_en     = entry_q.wb_en;
  assign out_wb_rd     = entry_q.wb_rd;
  assign out_wb_data   = entry_q.wb_data;
  assign out_mem_req   = entry_q.mem_req;
  assign out_mem_we    = entry_q.mem_we;
  assign out_mem_addr  = entry_q.mem_addr;
  assign out_mem_wdata = entry_q.mem_wdata;
  assign out_br_taken  = entry_q.br_taken;
  assign out_br_target = entry_q.br_target;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios then randomized traffic.
// Latency: expects results one cycle after accept.
// Backpressure: drives out_ready randomly and checks in_ready against the model.
module tb_alu_result_stage;
  import cpu_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // Branch encodings fixed by the architecture.
  localparam logic [4:0] TB_BEQ = 5'b10011;
  localparam logic [4:0] TB_BNE = 5'b10100;
  localparam logic [4:0] TB_BLT = 5'b10101;
  localparam logic [4:0] TB_BGT = 5'b10110;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_opcode;
  logic [DATA_W-1:0] in_alu_out;
  logic [1:0]        in_flags;
  logic [REG_AW-1:0] in_rd;
  logic [DATA_W-1:0] in_rd_old;
  logic [DATA_W-1:0] in_store_data;
  logic [DATA_W-1:0] in_br_target;
  logic              out_valid;
  logic              out_ready;
  logic              out_wb_en;
  logic [REG_AW-1:0] out_wb_rd;
  logic [DATA_W-1:0] out_wb_data;
  logic              out_mem_req;
  logic              out_mem_we;
  logic [DATA_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] out_mem_wdata;
  logic              out_br_taken;
  logic [DATA_W-1:0] out_br_target;
  logic [1:0]        flags_q;

  always #5 clk = ~clk;

  alu_result_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_alu_out    (in_alu_out),
    .in_flags      (in_flags),
    .in_rd         (in_rd),
    .in_rd_old     (in_rd_old),
    .in_store_data (in_store_data),
    .in_br_target  (in_br_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_wb_en     (out_wb_en),
    .out_wb_rd     (out_wb_rd),
    .out_wb_data   (out_wb_data),
    .out_mem_req   (out_mem_req),
    .out_mem_we    (out_mem_we),
    .out_mem_addr  (out_mem_addr),
    .out_mem_wdata (out_mem_wdata),
    .out_br_taken  (out_br_taken),
    .out_br_target (out_br_target),
    .flags_q       (flags_q)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what the stage should be presenting right now.
  typedef struct {
    logic              valid;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;
  } model_t;

  model_t     m;
  logic [1:0] m_flags;

  function automatic model_t empty_entry();
    model_t e;
    e.valid = 1'b0; e.wb_en = 1'b0; e.wb_rd = '0; e.wb_data = '0;
    e.mem_req = 1'b0; e.mem_we = 1'b0; e.mem_addr = '0; e.mem_wdata = '0;
    e.br_taken = 1'b0; e.br_target = '0;
    return e;
  endfunction

  // Architectural meaning of one op given the flags it observes.
  function automatic model_t predict(input logic [1:0] fl);
    model_t e;
    logic   arith, z, n, is_br;
    e      = empty_entry();
    e.valid = 1'b1;
    arith  = in_opcode inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV, OP_AND,
                               OP_ANDI, OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI};
    if (arith) e.wb_data = in_alu_out;
    if (in_opcode == OP_MOVEL) e.wb_data = (in_rd_old & 32'hFFFF0000) | (in_alu_out & 32'h0000FFFF);
    if (in_opcode == OP_MOVEH) e.wb_data = (in_alu_out & 32'hFFFF0000) | (in_rd_old & 32'h0000FFFF);
    e.wb_en = arith || in_opcode == OP_MOVEL || in_opcode == OP_MOVEH;
    e.wb_rd = e.wb_en ? in_rd : '0;
    e.mem_req   = (in_opcode == OP_LD) || (in_opcode == OP_ST);
    e.mem_we    = (in_opcode == OP_ST);
    e.mem_addr  = e.mem_req ? in_alu_out : '0;
    e.mem_wdata = e.mem_we ? in_store_data : '0;
    z = fl[0];
    n = fl[1];
    is_br = in_opcode inside {TB_BEQ, TB_BNE, TB_BLT, TB_BGT};
    e.br_taken = (in_opcode == TB_BEQ && z) || (in_opcode == TB_BNE && !z) ||
                 (in_opcode == TB_BLT && n) || (in_opcode == TB_BGT && !n && !z);
    e.br_target = is_br ? in_br_target : '0;
    return e;
  endfunction

  function automatic logic updates_flags(input logic [4:0] op);
`ifdef FLAGS_ON_ARITH_EN
    return op inside {OP_CMP, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV, OP_AND,
                      OP_ANDI, OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI};
`else
    return op == OP_CMP;
`endif
  endfunction

  // One clock: check the handshake, advance the model, compare all outputs.
  task automatic tick();
    model_t     nm;
    logic [1:0] nf;
    #1;
    if (!rst) check("in_ready", in_ready, !m.valid || out_ready);
    nm = m;
    nf = m_flags;
    if (rst) begin
      nm = empty_entry();
      nf = 2'b00;
    end else if (flush) begin
      nm = empty_entry();
    end else if (in_valid && (!m.valid || out_ready)) begin
      nm = predict(m_flags);
      if (updates_flags(in_opcode)) nf = in_flags;
    end else if (out_ready) begin
      nm = empty_entry();
    end
    @(posedge clk);
    #1;
    m       = nm;
    m_flags = nf;
    check("out_valid", out_valid, m.valid);
    check("wb_en", out_wb_en, m.wb_en);
    check("wb_rd", out_wb_rd, m.wb_rd);
    check("wb_data", out_wb_data, m.wb_data);
    check("mem_req", out_mem_req, m.mem_req);
    check("mem_we", out_mem_we, m.mem_we);
    check("mem_addr", out_mem_addr, m.mem_addr);
    check("mem_wdata", out_mem_wdata, m.mem_wdata);
    check("br_taken", out_br_taken, m.br_taken);
    check("br_target", out_br_target, m.br_target);
    check("flags_q", flags_q, m_flags);
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] alu, input logic [1:0] fl);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_alu_out = alu;
    in_flags   = fl;
  endtask

  logic [1:0] saved_flags;

  initial begin
    m       = empty_entry();
    m_flags = 2'b00;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = OP_ADD; in_alu_out = '0; in_flags = 2'b00; in_rd = 5'd3;
    in_rd_old = '0; in_store_data = '0; in_br_target = '0;
    tick();
    tick();
    check("reset_valid", out_valid, 1'b0);
    check("reset_flags", flags_q, 2'b00);
    rst = 1'b0;

    // CMP sets Z, then BEQ is taken.
    set_op(OP_CMP, 32'h0, 2'b01);
    tick();
    check("cmp_flags", flags_q, 2'b01);
    set_op(TB_BEQ, 32'h0, 2'b00);
    in_br_target = 32'h100;
    tick();
    check("beq_taken", out_br_taken, 1'b1);
    check("beq_target", out_br_target, 32'h100);

    // N set: BGT not taken, BLT and BNE taken.
    set_op(OP_CMP, 32'h0, 2'b10);
    tick();
    set_op(TB_BGT, 32'h0, 2'b00);
    tick();
    check("bgt_taken", out_br_taken, 1'b0);
    check("bgt_wb_en", out_wb_en, 1'b0);
    set_op(TB_BLT, 32'h0, 2'b00);
    tick();
    check("blt_taken", out_br_taken, 1'b1);
    set_op(TB_BNE, 32'h0, 2'b00);
    tick();
    check("bne_taken", out_br_taken, 1'b1);
    check("bne_wb_en", out_wb_en, 1'b0);

    // Half-word merges.
    in_rd_old = 32'hAAAA5555;
    set_op(OP_MOVEL, 32'h00001234, 2'b00);
    tick();
    check("movel_data", out_wb_data, 32'hAAAA1234);
    set_op(OP_MOVEH, 32'hBEEF0000, 2'b00);
    tick();
    check("moveh_data", out_wb_data, 32'hBEEF5555);

    // Memory requests.
    in_store_data = 32'hDEAD;
    set_op(OP_ST, 32'h40, 2'b00);
    tick();
    check("st_req", {out_mem_req, out_mem_we, out_wb_en}, 3'b110);
    check("st_addr", out_mem_addr, 32'h40);
    check("st_wdata", out_mem_wdata, 32'hDEAD);
    set_op(OP_LD, 32'h80, 2'b00);
    tick();
    check("ld_req", {out_mem_req, out_mem_we, out_wb_en}, 3'b100);

    // Backpressure: ADD result 7 held for three cycles.
    set_op(OP_ADD, 32'd7, 2'b00);
    tick();
    out_ready = 1'b0;
    set_op(OP_SUB, 32'd9, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_data", out_wb_data, 32'd7);
    end
    out_ready = 1'b1;
    tick();
    check("sub_after_hold", out_wb_data, 32'd9);

    // Flush beats an incoming CMP.
    saved_flags = m_flags;
    set_op(OP_CMP, 32'h0, 2'b11);
    flush = 1'b1;
    tick();
    check("flush_valid", out_valid, 1'b0);
    check("flush_flags", flags_q, saved_flags);
    flush = 1'b0;

    // Reset while an entry is held.
    set_op(OP_ADD, 32'd5, 2'b00);
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_hold_valid", out_valid, 1'b0);
    check("rst_hold_wb", out_wb_data, 32'd0);
    check("rst_hold_flags", flags_q, 2'b00);
    rst = 1'b0;
    out_ready = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 63) == 0);
      in_opcode     = 5'($urandom_range(0, 31));
      in_alu_out    = $urandom;
      in_flags      = 2'($urandom_range(0, 3));
      in_rd         = 5'($urandom_range(0, 31));
      in_rd_old     = $urandom;
      in_store_data = $urandom;
      in_br_target  = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
